sram_1rw_arb_ctrl: RTL and testbench

Two-requester front end for the single-port (1RW) OpenRAM SRAM macro. It arbitrates read/write requests round-robin and drives the macro's registered csb0/web0/addr0/din0 inputs. It returns read data with a fixed two-cycle latency. It also contains a sequential init engine that writes INIT_VALUE to every word after reset or on command. Sits between two bus-side clients and one sram_*_1rw macro instance.

---
 rtl/sram_1rw_arb_ctrl_pkg.sv | 15 +
 rtl/sram_1rw_arb_ctrl_rr_arb2.sv | 25 ++
 rtl/sram_1rw_arb_ctrl.sv | 123 ++++++++++++
 tb/tb_sram_1rw_arb_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_1rw_arb_ctrl_pkg.sv
// Shared types and defaults for the 1RW SRAM arbiter/controller slice.
package sram_ctrl_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 11;

  typedef enum logic {RUN, INIT} state_t;

  typedef logic req_id_t;

  function automatic logic [1:0] id_onehot(input req_id_t id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sram_1rw_arb_ctrl_rr_arb2.sv
// Two-input round-robin arbiter; the pointer moves past the winner on advance.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (advance && (gnt != 2'b00)) begin
      ptr <= gnt[0];
    end
  end

endmodule

// File: rtl/sram_1rw_arb_ctrl.sv
// Two-requester front end for a 1RW SRAM macro: round-robin issue, fixed
// two-cycle read return, and a sequential init sweep.
module sram_1rw_arb_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned           ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0,
  parameter bit                    INIT_ON_RESET = 1'b0
) (
  input  logic                    clk0,
  input  logic                    rst0_n,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_we,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  input  logic                    init_start,
  output logic                    init_busy,
  output logic                    init_done,
  output logic                    csb0,
  output logic                    web0,
  output logic [ADDR_WIDTH-1:0]   addr0,
  output logic [DATA_WIDTH-1:0]   din0,
  input  logic [DATA_WIDTH-1:0]   dout0
);

  state_t                state, state_nxt;
  logic                  init_pend;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  last_word;
  logic                  run_open;
  logic [1:0]            gnt;
  logic                  accept;
  req_id_t               acc_id;
  logic                  p1_v, p2_v;
  req_id_t               p1_id, p2_id;

  // Requests are only opened in RUN, outside reset, and not while an init is
  // being requested (explicitly or by the pending boot-time sweep).
  assign run_open  = rst0_n && (state == RUN) && !init_start && !init_pend;
  assign last_word = &cnt;
  assign init_busy = (state == INIT);

  rr_arb2 u_arb (
    .clk     (clk0),
    .rst_n   (rst0_n),
    .req     (req_valid & {2{run_open}}),
    .advance (accept),
    .gnt     (gnt)
  );

  assign req_ready = gnt;
  assign accept    = |gnt;
  assign acc_id    = gnt[1];

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (init_start || init_pend) state_nxt = INIT;
      INIT:    if (last_word) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      state     <= RUN;
      init_pend <= INIT_ON_RESET;
      cnt       <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      init_pend <= 1'b0;
      init_done <= (state == INIT) && last_word;
      cnt       <= (state == INIT) ? cnt + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      csb0  <= 1'b1;
      web0  <= 1'b1;
      addr0 <= '0;
      din0  <= '0;
    end else if (state == INIT) begin
      csb0  <= 1'b0;
      web0  <= 1'b0;
      addr0 <= cnt;
      din0  <= INIT_VALUE;
    end else if (accept) begin
      csb0  <= 1'b0;
      web0  <= ~req_we[acc_id];
      addr0 <= acc_id ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
      din0  <= acc_id ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
    end else begin
      csb0  <= 1'b1;
      web0  <= 1'b1;
    end
  end

  // Tag pipe: stage 1 covers the macro sampling edge, stage 2 the data edge.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      p1_v      <= 1'b0;
      p1_id     <= 1'b0;
      p2_v      <= 1'b0;
      p2_id     <= 1'b0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      p1_v      <= accept && !req_we[acc_id];
      p1_id     <= acc_id;
      p2_v      <= p1_v;
      p2_id     <= p1_id;
      rsp_valid <= p2_v ? id_onehot(p2_id) : 2'b00;
      if (p2_v) rsp_rdata <= dout0;
    end
  end

endmodule

// File: tb/tb_sram_1rw_arb_ctrl.sv
// Randomised and directed bench for sram_1rw_arb_ctrl with a transaction-level model.
module tb_sram_1rw_arb_ctrl;

  localparam int          DW    = 32;
  localparam int          AW    = 11;
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] IV    = 32'hA5A5A5A5;

  logic            clk0 = 1'b0;
  logic            rst0_n;
  logic [1:0]      req_valid, req_ready, req_we, rsp_valid;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, din0, dout0;
  logic            init_start, init_busy, init_done, csb0, web0;
  logic [AW-1:0]   addr0;

  always #5 clk0 = ~clk0;

  sram_1rw_arb_ctrl #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .INIT_VALUE    (IV),
    .INIT_ON_RESET (1'b1)
  ) dut (
    .clk0       (clk0),
    .rst0_n     (rst0_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .init_start (init_start),
    .init_busy  (init_busy),
    .init_done  (init_done),
    .csb0       (csb0),
    .web0       (web0),
    .addr0      (addr0),
    .din0       (din0),
    .dout0      (dout0)
  );

  // Behavioural 1RW macro: inputs sampled on posedge, read data after the edge.
  logic [DW-1:0] mem [0:DEPTH-1];
  always @(posedge clk0) begin
    if (!csb0) begin
      if (!web0) mem[addr0] <= din0;
      else       dout0 <= mem[addr0];
    end
  end

  // Reference model: expected memory contents plus a queue of due responses.
  typedef struct { int due; logic [1:0] id1h; logic [DW-1:0] data; } rsp_t;
  logic [DW-1:0] ref_mem [0:DEPTH-1];
  rsp_t          pend[$];
  int            ref_ptr, init_rem, cyc;
  bit            boot;
  int            chk, pass;
  logic [5:0]    g_obs, g_exp;
  logic [DW-1:0] g_obs_data, g_exp_data;
  logic [1:0]    g_acc;

  task automatic model_reset();
    pend.delete();
    ref_ptr  = 0;
    init_rem = 0;
    boot     = 1'b1;
  endtask

  // One clock: predicts ready before the edge, then the model's view after it.
  task automatic tick();
    logic [1:0]    er, erv;
    logic          edone;
    int            id;
    logic [AW-1:0] a;
    rsp_t          r;
    #1;
    er = 2'b00;
    if (init_rem == 0 && !boot && !init_start) begin
      if (req_valid == 2'b11) er = (ref_ptr == 0) ? 2'b01 : 2'b10;
      else                    er = req_valid;
    end
    g_obs[5:4] = req_ready;
    g_acc = er;
    @(posedge clk0);
    #1;
    cyc++;
    edone = 1'b0;
    if (init_rem > 0) begin
      ref_mem[DEPTH-init_rem] = IV;
      init_rem--;
      edone = (init_rem == 0);
    end else if (boot || init_start) begin
      init_rem = DEPTH;
    end else if (er != 2'b00) begin
      id = er[1] ? 1 : 0;
      a  = req_addr[id*AW +: AW];
      if (req_we[id]) ref_mem[a] = req_wdata[id*DW +: DW];
      else pend.push_back('{due: cyc + 2, id1h: er, data: ref_mem[a]});
      ref_ptr = 1 - id;
    end
    boot = 1'b0;
    erv = 2'b00;
    g_exp_data = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      r = pend.pop_front();
      erv = r.id1h;
      g_exp_data = r.data;
    end
    g_exp = {er, erv, (init_rem > 0), edone};
    g_obs[3:0] = {rsp_valid, init_busy, init_done};
    g_obs_data = rsp_rdata;
    @(negedge clk0);
  endtask

  task automatic bring_up();
    rst0_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk0);
    rst0_n = 1'b1;
    repeat (DEPTH + 1) tick();
  endtask

  task automatic test_reset();
    req_valid = 2'b11;
    #2 rst0_n = 1'b0;
    #1;
    chk++; if ({csb0, web0} !== 2'b11) $display("FAIL reset_csb_web got %b want 11", {csb0, web0}); else pass++;
    chk++; if ({addr0, din0, rsp_rdata} !== '0) $display("FAIL reset_data got %h want 0", {addr0, din0, rsp_rdata}); else pass++;
    chk++; if ({rsp_valid, init_busy, init_done, req_ready} !== 6'b0) $display("FAIL reset_ctl got %b want 000000", {rsp_valid, init_busy, init_done, req_ready}); else pass++;
    model_reset();
    @(negedge clk0); #1;
    chk++; if (req_ready !== 2'b00) $display("FAIL reset_ready got %b want 00", req_ready); else pass++;
    @(negedge clk0);
    rst0_n = 1'b1;
    req_valid = 2'b00;
  endtask

  task automatic test_init_on_reset();
    int busy_cnt, done_cnt, rdy_cnt;
    busy_cnt = 0; done_cnt = 0; rdy_cnt = 0;
    req_valid = 2'b01; req_we = 2'b00; req_addr[0 +: AW] = 11'h7FF;
    for (int n = 0; n < DEPTH + 1; n++) begin
      tick();
      chk++; if (g_obs !== g_exp) $display("FAIL init_step cyc=%0d got %b want %b", cyc, g_obs, g_exp); else pass++;
      busy_cnt += int'(g_obs[1]);
      done_cnt += int'(g_obs[0]);
      if (g_obs[5:4] != 2'b00) rdy_cnt++;
    end
    chk++; if (busy_cnt != DEPTH) $display("FAIL init_busy_len got %0d want %0d", busy_cnt, DEPTH); else pass++;
    chk++; if (done_cnt != 1) $display("FAIL init_done_pulses got %0d want 1", done_cnt); else pass++;
    chk++; if (rdy_cnt != 0) $display("FAIL init_ready_cycles got %0d want 0", rdy_cnt); else pass++;
    tick();
    chk++; if (g_obs[5:4] !== 2'b01) $display("FAIL init_post_grant got %b want 01", g_obs[5:4]); else pass++;
    req_valid = 2'b00;
    repeat (2) begin
      tick();
      chk++; if (g_obs !== g_exp) $display("FAIL init_drain cyc=%0d got %b want %b", cyc, g_obs, g_exp); else pass++;
    end
    chk++; if ({g_obs[3:2], g_obs_data} !== {2'b01, IV}) $display("FAIL init_read_7ff got %b/%h want 01/%h", g_obs[3:2], g_obs_data, IV); else pass++;
  endtask

  task automatic test_raw();
    req_valid = 2'b01; req_we = 2'b01; req_addr[0 +: AW] = 11'h005; req_wdata[0 +: DW] = 32'hDEADBEEF;
    tick();
    chk++; if (g_obs !== g_exp) $display("FAIL raw_write got %b want %b", g_obs, g_exp); else pass++;
    req_valid = 2'b10; req_we = 2'b00; req_addr[AW +: AW] = 11'h005;
    tick();
    chk++; if (g_obs !== g_exp) $display("FAIL raw_read got %b want %b", g_obs, g_exp); else pass++;
    req_valid = 2'b00;
    repeat (2) tick();
    chk++; if ({g_obs[3:2], g_obs_data} !== {2'b10, 32'hDEADBEEF}) $display("FAIL raw_data got %b/%h want 10/deadbeef", g_obs[3:2], g_obs_data); else pass++;
    chk++; if (g_obs_data !== g_exp_data) $display("FAIL raw_model got %h want %h", g_obs_data, g_exp_data); else pass++;
  endtask

  task automatic test_back_to_back();
    logic [1:0] gseq [4];
    logic [1:0] rseq [4];
    bring_up();
    req_valid = 2'b11; req_we = 2'b00;
    req_addr[0 +: AW] = 11'h001; req_addr[AW +: AW] = 11'h002;
    for (int n = 0; n < 6; n++) begin
      if (n == 4) req_valid = 2'b00;
      tick();
      chk++; if (g_obs !== g_exp) $display("FAIL b2b_step cyc=%0d got %b want %b", cyc, g_obs, g_exp); else pass++;
      if (g_exp[3:2] != 2'b00) begin
        chk++; if (g_obs_data !== g_exp_data) $display("FAIL b2b_data got %h want %h", g_obs_data, g_exp_data); else pass++;
      end
      if (n < 4)  gseq[n] = g_obs[5:4];
      if (n >= 2) rseq[n-2] = g_obs[3:2];
    end
    chk++; if ({gseq[0], gseq[1], gseq[2], gseq[3]} !== 8'b01_10_01_10) $display("FAIL b2b_grants got %b want 01100110", {gseq[0], gseq[1], gseq[2], gseq[3]}); else pass++;
    chk++; if ({rseq[0], rseq[1], rseq[2], rseq[3]} !== 8'b01_10_01_10) $display("FAIL b2b_rsp got %b want 01100110", {rseq[0], rseq[1], rseq[2], rseq[3]}); else pass++;
  endtask

  task automatic test_init_start_collision();
    int  waited, rsp1_cnt, done_cnt;
    bit  got;
    req_valid = 2'b10; req_we = 2'b00; req_addr[AW +: AW] = 11'h003;
    tick();
    chk++; if (g_obs !== g_exp) $display("FAIL coll_pre got %b want %b", g_obs, g_exp); else pass++;
    req_valid = 2'b01; req_addr[0 +: AW] = 11'h004; init_start = 1'b1;
    tick();
    chk++; if (g_obs[5:4] !== 2'b00) $display("FAIL coll_ready got %b want 00", g_obs[5:4]); else pass++;
    rsp1_cnt = int'(g_obs[3]);
    done_cnt = 0; waited = 0; got = 1'b0;
    while (!got && waited < DEPTH + 10) begin
      init_start = (waited == 100);
      tick();
      waited++;
      chk++; if (g_obs !== g_exp) $display("FAIL coll_step cyc=%0d got %b want %b", cyc, g_obs, g_exp); else pass++;
      if (g_exp[3:2] != 2'b00) begin
        chk++; if (g_obs_data !== g_exp_data) $display("FAIL coll_data got %h want %h", g_obs_data, g_exp_data); else pass++;
      end
      rsp1_cnt += int'(g_obs[3]);
      done_cnt += int'(g_obs[0]);
      if (g_obs[5:4] == 2'b01) got = 1'b1;
    end
    init_start = 1'b0;
    chk++; if (waited != DEPTH + 1) $display("FAIL coll_wait got %0d want %0d", waited, DEPTH + 1); else pass++;
    chk++; if (rsp1_cnt != 1) $display("FAIL coll_inflight_rsp got %0d want 1", rsp1_cnt); else pass++;
    chk++; if (done_cnt != 1) $display("FAIL coll_done got %0d want 1", done_cnt); else pass++;
    req_valid = 2'b00;
    repeat (2) tick();
    chk++; if ({g_obs[3:2], g_obs_data} !== {2'b01, g_exp_data}) $display("FAIL coll_late_rsp got %b/%h want 01/%h", g_obs[3:2], g_obs_data, g_exp_data); else pass++;
  endtask

  task automatic test_reset_mid();
    int rsp_cnt;
    req_valid = 2'b01; req_we = 2'b00; req_addr[0 +: AW] = 11'h006;
    tick();
    chk++; if (g_obs !== g_exp) $display("FAIL rmid_accept got %b want %b", g_obs, g_exp); else pass++;
    req_valid = 2'b00;
    #2 rst0_n = 1'b0;
    #1;
    chk++; if (csb0 !== 1'b1) $display("FAIL rmid_csb got %b want 1", csb0); else pass++;
    model_reset();
    repeat (2) @(negedge clk0);
    rst0_n = 1'b1;
    req_valid = 2'b11; req_addr[0 +: AW] = 11'h008; req_addr[AW +: AW] = 11'h009;
    rsp_cnt = 0;
    repeat (DEPTH + 1) begin
      tick();
      chk++; if (g_obs !== g_exp) $display("FAIL rmid_step cyc=%0d got %b want %b", cyc, g_obs, g_exp); else pass++;
      if (g_obs[3:2] != 2'b00) rsp_cnt++;
    end
    chk++; if (rsp_cnt != 0) $display("FAIL rmid_dropped got %0d want 0", rsp_cnt); else pass++;
    tick();
    chk++; if (g_obs[5:4] !== 2'b01) $display("FAIL rmid_rr_restart got %b want 01", g_obs[5:4]); else pass++;
    req_valid = 2'b00;
    repeat (2) begin
      tick();
      chk++; if (g_obs !== g_exp) $display("FAIL rmid_drain got %b want %b", g_obs, g_exp); else pass++;
    end
  endtask

  task automatic test_random();
    logic [1:0] hold;
    hold = 2'b00;
    for (int n = 0; n < 2700; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!hold[i] && $urandom_range(0, 9) < 6) begin
          hold[i] = 1'b1;
          req_we[i] = 1'($urandom_range(0, 1));
          req_addr[i*AW +: AW] = 11'($urandom_range(0, 15));
          req_wdata[i*DW +: DW] = $urandom;
        end
      end
      req_valid = hold;
      init_start = (n == 200);
      tick();
      chk++; if (g_obs !== g_exp) $display("FAIL rand_step cyc=%0d got %b want %b", cyc, g_obs, g_exp); else pass++;
      if (g_exp[3:2] != 2'b00) begin
        chk++; if (g_obs_data !== g_exp_data) $display("FAIL rand_data cyc=%0d got %h want %h", cyc, g_obs_data, g_exp_data); else pass++;
      end
      hold = hold & ~g_acc;
    end
    init_start = 1'b0;
    req_valid = 2'b00;
    repeat (3) begin
      tick();
      chk++; if (g_obs !== g_exp) $display("FAIL rand_drain got %b want %b", g_obs, g_exp); else pass++;
      if (g_exp[3:2] != 2'b00) begin
        chk++; if (g_obs_data !== g_exp_data) $display("FAIL rand_drain_data got %h want %h", g_obs_data, g_exp_data); else pass++;
      end
    end
  endtask

  initial begin
    rst0_n = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; init_start = 1'b0;
    chk = 0; pass = 0; cyc = 0; boot = 1'b0; init_rem = 0; ref_ptr = 0;
    repeat (2) @(negedge clk0);
    test_reset();
    test_init_on_reset();
    test_raw();
    test_back_to_back();
    test_init_start_collision();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
